mac_dot_ctrl: RTL and testbench
===============================

// Module: mac_dot_ctrl
// PURPOSE
//  Sequencer for the 16-bit multiply-accumulate datapath: runs one unsigned dot product of
//  length len over a streamed operand-pair source, clears the accumulator per job, drains the
//  pipeline and presents the sum with a valid/ready result handshake.
//  Sits between a command/operand producer and the result consumer.
// PARAMETERS
//  WIDTH   16  operand width (a, b), unsigned
//  ACC_W   40  accumulator/result width; must be >= 2*WIDTH
//  LEN_W   8   width of job length field (max len = 2**LEN_W-1)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        job request; sampled only in IDLE
//  len        in   LEN_W    number of operand pairs, sampled with start
//  busy       out  1        high in any state other than IDLE
//  in_valid   in   1        operand pair present
//  in_ready   out  1        controller accepts pair (STREAM only)
//  a, b       in   WIDTH    operand pair
//  res_valid  out  1        result available (DONE only)
//  res_ready  in   1        consumer takes result
//  result     out  ACC_W    dot-product sum, modulo 2**ACC_W
//  overflow   out  1        sticky per job: accumulator carried out of ACC_W
// BEHAVIOUR
//  - Reset: state=IDLE; busy, in_ready, res_valid, overflow = 0; result = 0; pipeline valid
//    bits and remaining-pair counter = 0. Reset mid-job discards all partial work.
//  - States IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
//  - IDLE: start && len!=0 -> STREAM, cnt=len, acc/overflow cleared.
//    start && len==0 -> DONE next edge, result=0, overflow=0. start outside IDLE ignored.
//  - STREAM: in_ready=1 (combinational from state). Pair accepted on edge with
//    in_valid && in_ready; cnt decrements. Accepting the pair with cnt==1 -> DRAIN.
//    in_valid gaps stall the job indefinitely; no timeout.
//  - Pipeline (fixed, PIPE_LAT=3): edge t accept -> S1 operand regs; t+1 product reg
//    (2*WIDTH, unsigned, zero-extended); t+2 acc += product. Each stage carries a valid bit;
//    only valid products accumulate.
//  - DRAIN: in_ready=0; leave to DONE when all stage valid bits are 0 after the final
//    accumulate, so res_valid is high from edge t+3 after the last accept at edge t.
//  - DONE: res_valid=1, result and overflow held stable until res_valid && res_ready,
//    then IDLE on that edge. start in that same cycle is ignored (must be reasserted).
//  - Overflow: set when acc + product carries out of bit ACC_W-1; stays set until next job.
//  - in_ready never high outside STREAM; res_valid never high outside DONE.
//  - Throughput: one pair per cycle in STREAM; one idle cycle minimum between jobs.
// STRUCTURE
//  - Package mac_ctrl_pkg: state enum (IDLE, STREAM, DRAIN, DONE), localparam PIPE_LAT=3.
//  - Sub-module mac_pipe_unit: 3-stage unsigned multiply-accumulate with in_vld, clr,
//    per-stage valid bits, acc, ovf, and an empty flag; mac_dot_ctrl holds FSM + counter.
// TESTING
//  1 len=3, pairs (2,3),(4,5),(6,7) back-to-back -> result=68, overflow=0, res_valid at
//    edge last_accept+3, busy low the cycle after res handshake.
//  2 Same job with in_valid low 2 cycles between pairs -> in_ready high throughout STREAM,
//    result=68, no extra pairs accepted.
//  3 start with len=0 -> DONE next edge, result=0, res_valid=1, in_ready never asserted.
//  4 ACC_W=32 override, len=2, pairs (0xFFFF,0xFFFF) x2 -> result=0xFFFC0002, overflow=1;
//    next job len=1 (1,1) -> result=1, overflow=0.
//  5 rst asserted in STREAM after 2 of len=4 pairs -> next edge all outputs at reset
//    values; new job len=1 (3,3) -> result=9 (no residue).
//  6 res_ready low 5 cycles in DONE, start pulsed meanwhile -> result stable, start
//    ignored, busy=1 until handshake, then IDLE.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_ctrl_pkg
// Purpose  : Shared constants for the dot-product MAC sequencer. This package
//            holds the controller state encoding and the fixed pipeline depth
//            of the multiply-accumulate unit.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mac_ctrl_pkg;

    // Accept -> operand regs -> product reg -> accumulator.
    localparam int unsigned PIPE_LAT = 3;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage : mac_ctrl_pkg
`default_nettype wire

// File: rtl/mac_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module   : mac_pipe_unit
// Purpose  : Three-stage unsigned multiply-accumulate. Stage 1 registers the
//            operand pair, stage 2 registers the full-width product, and
//            stage 3 adds a valid product into the accumulator. A carry out
//            of the accumulator sets a sticky overflow flag.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            clr             - clear accumulator and overflow (new job)
//            in_vld, a, b    - operand pair entering stage 1
//            acc, ovf        - accumulator value and sticky overflow
//            empty           - no valid data in stage 1 or stage 2
// Revision : 1.0 - initial release
// ============================================================================
module mac_pipe_unit
    import mac_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic             empty
);

    localparam int unsigned PROD_W = 2 * WIDTH;

    // Stage 1: operand registers
    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] s1_a_q,   s1_a_d;
    logic [WIDTH-1:0] s1_b_q,   s1_b_d;

    // Stage 2: product register
    logic              prod_vld_q, prod_vld_d;
    logic [PROD_W-1:0] prod_q,     prod_d;

    // Stage 3: accumulator
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;

    // One extra bit so the carry out of the accumulator is visible.
    logic [ACC_W:0]   w_sum;

    always_comb begin
        s1_vld_d   = in_vld;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        prod_vld_d = s1_vld_q;
        prod_d     = prod_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;

        w_sum = {1'b0, acc_q} + (ACC_W + 1)'(prod_q);

        // Operand and product registers only move when carrying valid data,
        // which keeps idle-cycle toggling out of the multiplier.
        if (in_vld) begin
            s1_a_d = a;
            s1_b_d = b;
        end

        if (s1_vld_q) begin
            prod_d = PROD_W'(s1_a_q) * PROD_W'(s1_b_q);
        end

        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (prod_vld_q) begin
            acc_d = w_sum[ACC_W-1:0];
            ovf_d = ovf_q | w_sum[ACC_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q   <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            prod_vld_q <= 1'b0;
            prod_q     <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            prod_vld_q <= prod_vld_d;
            prod_q     <= prod_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
        end
    end

    assign acc   = acc_q;
    assign ovf   = ovf_q;
    assign empty = ~s1_vld_q & ~prod_vld_q;

endmodule : mac_pipe_unit
`default_nettype wire

// File: rtl/mac_dot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac_dot_ctrl
// Purpose  : Sequencer for one unsigned dot product of length len over a
//            streamed operand-pair source. Clears the accumulator per job,
//            drains the MAC pipeline and presents the sum with a valid/ready
//            result handshake.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            start, len             - job request (sampled only in IDLE)
//            busy                   - high in any state other than IDLE
//            in_valid, in_ready     - operand pair handshake (STREAM only)
//            a, b                   - operand pair
//            res_valid, res_ready   - result handshake (DONE only)
//            result                 - dot-product sum modulo 2**ACC_W
//            overflow               - sticky per-job accumulator carry-out
// Revision : 1.0 - initial release
// ============================================================================
module mac_dot_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ACC_W = 40,   // must be >= 2*WIDTH
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow
);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;

    logic             w_accept;
    logic             w_clr;
    logic             w_pipe_empty;

    assign w_accept = in_valid & (state_q == ST_STREAM);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_clr   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Accumulator is cleared for every job, including the
                    // zero-length one that reports 0 immediately.
                    w_clr = 1'b1;
                    if (len != '0) begin
                        state_d = ST_STREAM;
                        cnt_d   = len;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_STREAM: begin
                if (w_accept) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The last pair is accepted on entry, so the pipe is never
                // empty in the first DRAIN cycle; empty here means the final
                // accumulate has already landed.
                if (w_pipe_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here: a request that
                // coincides with the result handshake is dropped.
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mac_pipe_unit #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clr),
        .in_vld (w_accept),
        .a      (a),
        .b      (b),
        .acc    (result),
        .ovf    (overflow),
        .empty  (w_pipe_empty)
    );

    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = (state_q == ST_STREAM);
    assign res_valid = (state_q == ST_DONE);

endmodule : mac_dot_ctrl
`default_nettype wire

// File: tb/tb_mac_dot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_dot_ctrl
// Purpose  : Self-checking bench for mac_dot_ctrl. Two instances (ACC_W=40
//            and ACC_W=32) share one stimulus stream; a job-level model
//            predicts handshake timing and the exact arithmetic sum, and a
//            negedge process compares both instances against it each cycle.
//            Directed jobs add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_dot_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        in_valid = 1'b0;
    logic [15:0] a = 16'd0;
    logic [15:0] b = 16'd0;
    logic        res_ready = 1'b0;

    logic        busy_a, in_ready_a, res_valid_a, overflow_a;
    logic [39:0] result_a;
    logic        busy_b, in_ready_b, res_valid_b, overflow_b;
    logic [31:0] result_b;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    mac_dot_ctrl u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy_a),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .a         (a),
        .b         (b),
        .res_valid (res_valid_a),
        .res_ready (res_ready),
        .result    (result_a),
        .overflow  (overflow_a)
    );

    mac_dot_ctrl #(
        .ACC_W (32)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .a         (a),
        .b         (b),
        .res_valid (res_valid_b),
        .res_ready (res_ready),
        .result    (result_b),
        .overflow  (overflow_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Job-level model: exact sum in 64 bits, phase flags for handshakes.
    // ------------------------------------------------------------------
    logic [63:0] m_sum   = 64'd0;
    int          m_left  = 0;
    int          m_drain = 0;
    bit          m_busy  = 1'b0;
    bit          m_stream = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_fresh = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            m_sum    <= 64'd0;
            m_left   <= 0;
            m_drain  <= 0;
            m_busy   <= 1'b0;
            m_stream <= 1'b0;
            m_done   <= 1'b0;
            m_fresh  <= 1'b1;
        end else if (m_done) begin
            if (res_ready) begin
                m_done <= 1'b0;
                m_busy <= 1'b0;
            end
        end else if (m_drain > 0) begin
            m_drain <= m_drain - 1;
            if (m_drain == 1) m_done <= 1'b1;
        end else if (m_stream) begin
            if (in_valid) begin
                m_sum  <= m_sum + 64'(a) * 64'(b);
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_stream <= 1'b0;
                    m_drain  <= 3;
                end
            end
        end else if (start) begin
            m_busy  <= 1'b1;
            m_fresh <= 1'b0;
            m_sum   <= 64'd0;
            if (len == 8'd0) begin
                m_done <= 1'b1;
            end else begin
                m_stream <= 1'b1;
                m_left   <= int'(len);
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("busy_a",      busy_a,      m_busy);
            chk("busy_b",      busy_b,      m_busy);
            chk("in_ready_a",  in_ready_a,  m_stream);
            chk("in_ready_b",  in_ready_b,  m_stream);
            chk("res_valid_a", res_valid_a, m_done);
            chk("res_valid_b", res_valid_b, m_done);
            if (m_done || m_fresh) begin
                chk("result_a",   result_a,   m_sum[39:0]);
                chk("overflow_a", overflow_a, |m_sum[63:40]);
                chk("result_b",   result_b,   m_sum[31:0]);
                chk("overflow_b", overflow_b, |m_sum[63:32]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: all drive at posedge+1.
    // ------------------------------------------------------------------
    task automatic start_job(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] x, input logic [15:0] y, input int gap);
        in_valid = 1'b1;
        a = x;
        b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int n = 0;
        while (res_valid_a !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_res_valid"}, res_valid_a, 1'b1);
        chk({tag, "_latency"}, n, exp_lat);
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checking = 1'b1;
        chk("rst_busy",      busy_a,      1'b0);
        chk("rst_in_ready",  in_ready_a,  1'b0);
        chk("rst_res_valid", res_valid_a, 1'b0);
        chk("rst_result",    result_a,    40'd0);
        chk("rst_overflow",  overflow_a,  1'b0);
        @(posedge clk); #1;

        // 1: len=3 back-to-back, 2*3+4*5+6*7 = 68, result 3 edges after last accept
        start_job(8'd3);
        send_pair(16'd2, 16'd3, 0);
        send_pair(16'd4, 16'd5, 0);
        send_pair(16'd6, 16'd7, 0);
        wait_result("t1", 3);
        chk("t1_result",   result_a,   40'd68);
        chk("t1_overflow", overflow_a, 1'b0);
        take_result();
        chk("t1_busy_after", busy_a, 1'b0);

        // 2: same job with 2-cycle gaps; junk pair held valid during drain
        start_job(8'd3);
        send_pair(16'd2, 16'd3, 2);
        send_pair(16'd4, 16'd5, 2);
        in_valid = 1'b1; a = 16'd6; b = 16'd7;
        @(posedge clk); #1;
        a = 16'd100; b = 16'd100;
        wait_result("t2", 3);
        chk("t2_result", result_a, 40'd68);
        take_result();
        in_valid = 1'b0;
        @(posedge clk); #1;

        // 3: zero-length job finishes on the next edge
        start_job(8'd0);
        wait_result("t3", 0);
        chk("t3_result", result_a, 40'd0);
        take_result();

        // 4: 2 x 0xFFFF^2 = 0x1FFFC0002 wraps a 32-bit accumulator only
        start_job(8'd2);
        send_pair(16'hFFFF, 16'hFFFF, 0);
        send_pair(16'hFFFF, 16'hFFFF, 0);
        wait_result("t4", 3);
        chk("t4_result_b",   result_b,   32'hFFFC_0002);
        chk("t4_overflow_b", overflow_b, 1'b1);
        chk("t4_result_a",   result_a,   40'h1_FFFC_0002);
        chk("t4_overflow_a", overflow_a, 1'b0);
        take_result();
        start_job(8'd1);
        send_pair(16'd1, 16'd1, 0);
        wait_result("t4b", 3);
        chk("t4b_result_b",   result_b,   32'd1);
        chk("t4b_overflow_b", overflow_b, 1'b0);
        take_result();

        // 5: reset in the middle of a job, then a clean job
        start_job(8'd4);
        send_pair(16'd10, 16'd10, 0);
        send_pair(16'd20, 16'd20, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_busy",      busy_a,      1'b0);
        chk("t5_in_ready",  in_ready_a,  1'b0);
        chk("t5_res_valid", res_valid_a, 1'b0);
        chk("t5_result",    result_a,    40'd0);
        chk("t5_overflow",  overflow_a,  1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        start_job(8'd1);
        send_pair(16'd3, 16'd3, 0);
        wait_result("t5", 3);
        chk("t5_result_after", result_a, 40'd9);
        take_result();

        // 6: consumer stalls in DONE while start is pulsed
        start_job(8'd1);
        send_pair(16'd2, 16'd2, 0);
        wait_result("t6", 3);
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 8'd5;
            @(posedge clk); #1;
            chk("t6_hold_result", result_a, 40'd4);
            chk("t6_hold_busy",   busy_a,   1'b1);
        end
        start = 1'b1;
        len   = 8'd2;
        take_result();
        start = 1'b0;
        chk("t6_busy_after", busy_a, 1'b0);
        @(posedge clk); #1;
        chk("t6_still_idle", busy_a, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mac_dot_ctrl
`default_nettype wire
